// File: rtl/cache_fill_ctrl.sv
// cache_fill_ctrl: controller for cache line fills and store forwarding.
// A miss fetches an aligned 16-byte block as 8 halfword reads from a
// multicycle memory. Each returned word is written into the data array, and
// the tag array is written with the last word. In IDLE, stores are forwarded
// straight to memory. They stall while a fill is in progress.
// Configuration macro: PIPELINED_FILL_EN. When defined, one read is issued
// per cycle. When undefined (the default), the next read is issued only when
// the previous word returns.
module cache_fill_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        miss_detected,
  input  logic [15:0] miss_address,
  input  logic        wr_req,
  input  logic [15:0] wr_addr,
  input  logic [15:0] wr_data,
  output logic        wr_ack,
  output logic        mem_enable,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_data_in,
  input  logic        mem_data_valid,
  input  logic [15:0] mem_data_out,
  output logic        fsm_busy,
  output logic        write_data_array,
  output logic        write_tag_array,
  output logic [15:0] cache_addr,
  output logic [15:0] cache_data
);

`ifdef PIPELINED_FILL_EN
  localparam logic PIPELINED = 1'b1;
`else
  localparam logic PIPELINED = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;

  state_t      state, state_next;
  logic [11:0] base, base_next;
  logic [2:0]  issue_cnt, issue_next;
  logic [2:0]  recv_cnt, recv_next;
  logic        issue_now;

  // State, block base and word counters; reset drops any fill in progress
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      base      <= '0;
      issue_cnt <= '0;
      recv_cnt  <= '0;
    end else begin
      state     <= state_next;
      base      <= base_next;
      issue_cnt <= issue_next;
      recv_cnt  <= recv_next;
    end
  end

  // Next-state and output decode; every output is gated to 0 while in reset
  always_comb begin
    state_next       = state;
    base_next        = base;
    issue_next       = issue_cnt;
    recv_next        = recv_cnt;
    issue_now        = 1'b0;
    wr_ack           = 1'b0;
    mem_enable       = 1'b0;
    mem_wr           = 1'b0;
    mem_addr         = '0;
    mem_data_in      = '0;
    fsm_busy         = 1'b0;
    write_data_array = 1'b0;
    write_tag_array  = 1'b0;
    cache_addr       = '0;
    cache_data       = '0;
    if (rst_n) begin
      case (state)
        IDLE: begin
          if (wr_req) begin
            wr_ack      = 1'b1;
            mem_enable  = 1'b1;
            mem_wr      = 1'b1;
            mem_addr    = {wr_addr[15:1], 1'b0};
            mem_data_in = wr_data;
          end else if (miss_detected) begin
            mem_enable = 1'b1;
            mem_addr   = {miss_address[15:4], 4'b0000};
            fsm_busy   = 1'b1;
            base_next  = miss_address[15:4];
            issue_next = 3'd1;
            recv_next  = 3'd0;
            state_next = FILL;
          end
        end
        FILL, DRAIN: begin
          fsm_busy = 1'b1;
          if (state == FILL) begin
            issue_now = PIPELINED | (mem_data_valid && (recv_cnt != 3'd7));
            if (issue_now) begin
              mem_enable = 1'b1;
              mem_addr   = {base, issue_cnt, 1'b0};
              issue_next = issue_cnt + 3'd1;
              if (issue_cnt == 3'd7) begin
                state_next = DRAIN;
              end
            end
          end
          if (mem_data_valid) begin
            write_data_array = 1'b1;
            cache_addr       = {base, recv_cnt, 1'b0};
            cache_data       = mem_data_out;
            recv_next        = recv_cnt + 3'd1;
            if (recv_cnt == 3'd7) begin
              write_tag_array = 1'b1;
              state_next      = IDLE;
              issue_next      = 3'd0;
              recv_next       = 3'd0;
            end
          end
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// tb_cache_fill_ctrl: self-checking bench for cache_fill_ctrl.
// A fixed 4-cycle memory answers every read the DUT issues. Expected read and
// write timing is derived from the block rules. A fill issued at cycle 0 reads
// word i at cycle i (pipelined) or 4*i (default). Each word returns 4 cycles
// after its read, and the tag write comes with the last word.
// Honours PIPELINED_FILL_EN the same way as the design.
module tb_cache_fill_ctrl;

`ifdef PIPELINED_FILL_EN
  localparam bit PIPE = 1'b1;
`else
  localparam bit PIPE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        miss_detected;
  logic [15:0] miss_address;
  logic        wr_req;
  logic [15:0] wr_addr;
  logic [15:0] wr_data;
  logic        wr_ack;
  logic        mem_enable;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_data_in;
  logic        mem_data_valid;
  logic [15:0] mem_data_out;
  logic        fsm_busy;
  logic        write_data_array;
  logic        write_tag_array;
  logic [15:0] cache_addr;
  logic [15:0] cache_data;

  int          tests_run = 0;
  int          tests_failed = 0;
  int          cyc = 0;
  logic [15:0] salt = 16'h5A5A;
  logic [15:0] pend_addr[$];
  int          pend_due[$];

  cache_fill_ctrl dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .miss_detected    (miss_detected),
    .miss_address     (miss_address),
    .wr_req           (wr_req),
    .wr_addr          (wr_addr),
    .wr_data          (wr_data),
    .wr_ack           (wr_ack),
    .mem_enable       (mem_enable),
    .mem_wr           (mem_wr),
    .mem_addr         (mem_addr),
    .mem_data_in      (mem_data_in),
    .mem_data_valid   (mem_data_valid),
    .mem_data_out     (mem_data_out),
    .fsm_busy         (fsm_busy),
    .write_data_array (write_data_array),
    .write_tag_array  (write_tag_array),
    .cache_addr       (cache_addr),
    .cache_data       (cache_data)
  );

  // Free-running clock, 10 time units per cycle
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [79:0] got, input logic [79:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    logic [15:0] prod;
    prod = a * 16'h9E37;
    return prod ^ salt;
  endfunction

  function automatic logic [79:0] all_outs();
    return 80'({mem_enable, mem_wr, wr_ack, fsm_busy, write_data_array, write_tag_array,
                mem_addr, mem_data_in, cache_addr, cache_data});
  endfunction

  // Word index read in cycle c of a fill, or -1 when no read is due then
  function automatic int read_at(input int c);
    for (int i = 0; i < 8; i++) begin
      if ((PIPE ? i : 4 * i) == c) return i;
    end
    return -1;
  endfunction

  task automatic applyStimulus(input logic miss, input logic [15:0] maddr,
                               input logic wr, input logic [15:0] waddr,
                               input logic [15:0] wdata);
    miss_detected = miss;
    miss_address  = maddr;
    wr_req        = wr;
    wr_addr       = waddr;
    wr_data       = wdata;
    #1;
  endtask

  // Advance one cycle and present any memory response that has come due
  task automatic next_cycle();
    @(posedge clk);
    #1;
    cyc++;
    mem_data_valid = 1'b0;
    mem_data_out   = '0;
    if (pend_due.size() > 0 && pend_due[0] == cyc) begin
      mem_data_valid = 1'b1;
      mem_data_out   = mem_word(pend_addr[0]);
      void'(pend_due.pop_front());
      void'(pend_addr.pop_front());
    end
  endtask

  task automatic capture_read();
    if (rst_n && mem_enable && !mem_wr) begin
      pend_addr.push_back(mem_addr);
      pend_due.push_back(cyc + 4);
    end
  endtask

  task automatic run_fill(input logic [15:0] addr, input bit hold_wr);
    logic [15:0] base;
    logic [15:0] waddr;
    logic [15:0] wdata;
    int          t_end;
    int          ri;
    int          wi;
    base  = {addr[15:4], 4'h0};
    waddr = 16'($urandom);
    wdata = 16'($urandom);
    t_end = PIPE ? 11 : 32;
    salt  = 16'($urandom);
    for (int c = 0; c <= t_end + 1; c++) begin
      next_cycle();
      if (c == 0)
        applyStimulus(1'b1, addr, 1'b0, 16'h0, 16'h0);
      else if (c <= t_end)
        applyStimulus(1'($urandom_range(0, 1)), 16'($urandom), hold_wr, waddr, wdata);
      else
        applyStimulus(1'b0, 16'h0, hold_wr, waddr, wdata);
      if (c <= t_end) begin
        ri = read_at(c);
        wi = read_at(c - 4);
        checkOutput("busy", 80'(fsm_busy), 80'(1));
        checkOutput("wr_ack_stall", 80'(wr_ack), 80'(0));
        if (ri >= 0)
          checkOutput("fill_read", 80'({mem_enable, mem_wr, mem_addr}),
                      80'({1'b1, 1'b0, base | 16'(ri * 2)}));
        else
          checkOutput("no_read", 80'(mem_enable), 80'(0));
        if (wi >= 0)
          checkOutput("data_write", 80'({write_data_array, cache_addr, cache_data}),
                      80'({1'b1, base | 16'(wi * 2), mem_word(base | 16'(wi * 2))}));
        else
          checkOutput("no_write", 80'(write_data_array), 80'(0));
        checkOutput("tag_write", 80'(write_tag_array), 80'(c == t_end));
      end else begin
        checkOutput("idle_busy", 80'(fsm_busy), 80'(0));
        if (hold_wr)
          checkOutput("held_store", 80'({wr_ack, mem_enable, mem_wr, mem_addr, mem_data_in}),
                      80'({3'b111, waddr & 16'hFFFE, wdata}));
        else
          checkOutput("idle_quiet", 80'({mem_enable, wr_ack}), 80'(0));
      end
      capture_read();
    end
    wr_req        = 1'b0;
    miss_detected = 1'b0;
  endtask

  task automatic reset_mid_fill(input logic [15:0] addr);
    for (int c = 0; c < 5; c++) begin
      next_cycle();
      applyStimulus(c == 0, addr, 1'b0, 16'h0, 16'h0);
      capture_read();
    end
    for (int c = 5; c < 7; c++) begin
      next_cycle();
      rst_n = 1'b0;
      applyStimulus(1'b1, 16'($urandom), 1'b1, 16'($urandom), 16'($urandom));
      checkOutput("reset_midfill", all_outs(), 80'(0));
      capture_read();
    end
    rst_n = 1'b1;
    applyStimulus(1'b0, 16'h0, 1'b0, 16'h0, 16'h0);
    for (int k = 0; k < 12; k++) begin
      next_cycle();
      applyStimulus(1'b0, 16'h0, 1'b0, 16'h0, 16'h0);
      checkOutput("stale_valid", 80'({write_data_array, write_tag_array, fsm_busy}), 80'(0));
      capture_read();
    end
  endtask

  initial begin
    rst_n          = 1'b0;
    mem_data_valid = 1'b0;
    mem_data_out   = 16'h0;
    applyStimulus(1'b1, 16'h1236, 1'b1, 16'h0040, 16'hBEEF);
    repeat (2) @(posedge clk);
    #2;
    checkOutput("reset_outputs", all_outs(), 80'(0));
    rst_n = 1'b1;
    applyStimulus(1'b0, 16'h0, 1'b0, 16'h0, 16'h0);

    for (int k = 0; k < 3; k++) begin
      next_cycle();
      mem_data_valid = 1'b1;
      mem_data_out   = 16'($urandom);
      applyStimulus(1'b0, 16'h0, 1'b0, 16'h0, 16'h0);
      checkOutput("idle_valid_ignored",
                  80'({write_data_array, write_tag_array, fsm_busy}), 80'(0));
    end

    next_cycle();
    applyStimulus(1'b1, 16'h1236, 1'b1, 16'h0040, 16'hBEEF);
    checkOutput("wr_priority",
                80'({wr_ack, mem_enable, mem_wr, mem_addr, mem_data_in, fsm_busy}),
                80'({3'b111, 16'h0040, 16'hBEEF, 1'b0}));
    capture_read();
    run_fill(16'h1236, 1'b0);

    run_fill(16'h1236, 1'b1);

    for (int k = 0; k < 6; k++) begin
      run_fill(16'($urandom), 1'($urandom_range(0, 1)));
    end

    reset_mid_fill(16'h1236);
    run_fill(16'h2000, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/cache_fill_ctrl.md
CACHE_FILL_CTRL -- requirements
Module: cache_fill_ctrl

Interface
REQ-001 SHALL have ports: clk in 1, system clock (all state on rising edge).
REQ-002 SHALL have: rst_n in 1, asynchronous active-low reset.
REQ-003 SHALL have: miss_detected in 1, cache miss request; miss_address in 16, byte address of missing word.
REQ-004 SHALL have: wr_req in 1, core store request; wr_addr in 16; wr_data in 16; wr_ack out 1, store forwarded this cycle.
REQ-005 SHALL have: mem_enable out 1; mem_wr out 1; mem_addr out 16; mem_data_in out 16; mem_data_valid in 1; mem_data_out in 16, the multicycle memory port.
REQ-006 SHALL have: fsm_busy out 1; write_data_array out 1; write_tag_array out 1; cache_addr out 16; cache_data out 16.

Function
REQ-007 SHALL use a 16-byte block of 8 words, with mem_addr[0] and cache_addr[0] always 0.
REQ-008 SHALL have states IDLE, FILL, DRAIN, with all outputs combinational from state, counters and inputs.
REQ-009 IDLE with wr_req=1 SHALL drive mem_enable=1, mem_wr=1, mem_addr=wr_addr, mem_data_in=wr_data, wr_ack=1 in the same cycle and remain IDLE.
REQ-010 wr_req SHALL take priority over a simultaneous miss_detected, which is accepted on the first IDLE cycle with wr_req=0.
REQ-011 IDLE with miss_detected=1 and wr_req=0 SHALL latch block base miss_address[15:4], issue word 0 (mem_enable=1, mem_wr=0), assert fsm_busy and go to FILL.
REQ-012 In FILL, word issue_cnt SHALL go to mem_addr={base,issue_cnt,1'b0}.
REQ-013 FILL SHALL go to DRAIN after word 7 is issued.
REQ-014 fsm_busy SHALL be 1 in FILL and DRAIN and in the acceptance cycle; wr_ack SHALL be 0 outside IDLE, so stores stall.
REQ-015 Every mem_data_valid=1 outside IDLE SHALL assert write_data_array=1 with cache_data=mem_data_out and cache_addr={base,recv_cnt[2:0],1'b0}, then increment recv_cnt.
REQ-016 The 8th valid SHALL assert write_tag_array=1 in the same cycle; the next state SHALL be IDLE with counters cleared.
REQ-017 mem_data_valid in IDLE SHALL be ignored, with no array writes.
REQ-018 Completion SHALL depend only on the number of valid pulses, never on an assumed latency.
REQ-019 miss_detected and miss_address changes during FILL/DRAIN SHALL be ignored.
REQ-020 mem_wr SHALL be 0 whenever a fill read is issued.

Reset
REQ-021 rst_n=0 SHALL immediately force IDLE and clear issue_cnt, recv_cnt and the latched base, including mid-fill.
REQ-022 While rst_n=0, all outputs SHALL be 0.
REQ-023 After rst_n deasserts, the first miss SHALL be accepted no earlier than the first rising edge with rst_n=1.

Configuration
REQ-024 With PIPELINED_FILL_EN defined, FILL SHALL issue one read per cycle, words 0..7 in cycles 0..7, with 4-cycle memory valids in cycles 4..11 and the tag write in cycle 11.
REQ-025 Without PIPELINED_FILL_EN, the next read SHALL issue only in a cycle where mem_data_valid=1 and recv_cnt<7.
REQ-026 In non-pipelined mode, reads SHALL issue at cycles 0,4,...,28 with the tag write in cycle 32.

Verification
REQ-027 Pipelined: miss at 0x1236 from IDLE -> mem_addr 0x1230..0x123E cycles 0-7; write_data_array cycles 4-11; write_tag_array cycle 11; fsm_busy 0-11; IDLE cycle 12.
REQ-028 Non-pipelined: same miss -> 8 reads 4 cycles apart; tag write cycle 32; cache_addr 0x1230 with first valid, 0x123E with last.
REQ-029 wr_req and miss_detected both high in cycle 0, wr_addr 0x0040, wr_data 0xBEEF -> cycle 0 mem_wr=1, wr_ack=1; miss accepted cycle 1.
REQ-030 wr_req held during fill -> wr_ack=0 until IDLE, then mem_wr=1 with held data for one cycle.
REQ-031 rst_n low at cycle 5 of a pipelined fill -> outputs 0 immediately; stale valids after release give no array writes; new miss 0x2000 fills 0x2000..0x200E correctly.
